// File: rtl/display_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : display_scheduler_if
// Description : Digit-source bundle between the clock core and the display
//               scheduler. The master side supplies the digit sources and
//               requests. The slave side (the scheduler) returns the digit
//               codes, the source indicator and the step strobe.
// Revision    : 1.0 - initial release
// ============================================================================
interface display_scheduler_if;
    logic [15:0] time_digits;
    logic [39:0] date_digits;
    logic [15:0] alarm_digits;
    logic        alarm_req;
    logic        mode_btn;
    logic [15:0] disp_code;
    logic [1:0]  src;
    logic        step;

    modport master (
        output time_digits, date_digits, alarm_digits, alarm_req, mode_btn,
        input  disp_code, src, step
    );

    modport slave (
        input  time_digits, date_digits, alarm_digits, alarm_req, mode_btn,
        output disp_code, src, step
    );
endinterface
`default_nettype wire

// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : display_scheduler
// Description : Chooses what the four 7-segment digits show. The sources are
//               live time, a one-shot scrolling date marquee and a blinking
//               alarm readout. A local prescaler paces the scroll and blink
//               steps.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scheduler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    display_scheduler_if.slave  bus
);

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [2:0]      POS_LAST  = 3'd6;
    localparam logic [15:0]     BLANK     = 16'hFFFF;

    // The encoding doubles as the src indicator value.
    typedef enum logic [1:0] {
        S_TIME  = 2'd0,
        S_DATE  = 2'd1,
        S_ALARM = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  presc, presc_nxt;
    logic [2:0]     pos, pos_nxt;
    logic           blink, blink_nxt;
    logic [15:0]    disp_q, disp_nxt;
    logic [1:0]     src_q, src_nxt;
    logic           tick;
    logic [15:0]    window;

    // The strobe comes straight from the prescaler value. It is never gated by state.
    assign tick = (presc == PRESC_MAX);

    // State, prescaler, marquee position, blink phase and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_TIME;
            presc  <= '0;
            pos    <= 3'd0;
            blink  <= 1'b0;
            disp_q <= BLANK;
            src_q  <= 2'd0;
        end else begin
            state  <= state_nxt;
            presc  <= presc_nxt;
            pos    <= pos_nxt;
            blink  <= blink_nxt;
            disp_q <= disp_nxt;
            src_q  <= src_nxt;
        end
    end

    // Four-character window of the date string that starts at char pos.
    always_comb begin
        window = BLANK;
        case (pos)
            3'd0:    window = bus.date_digits[39:24];
            3'd1:    window = bus.date_digits[35:20];
            3'd2:    window = bus.date_digits[31:16];
            3'd3:    window = bus.date_digits[27:12];
            3'd4:    window = bus.date_digits[23:8];
            3'd5:    window = bus.date_digits[19:4];
            3'd6:    window = bus.date_digits[15:0];
            default: window = BLANK;
        endcase
    end

    // Next-state logic. Alarm beats the marquee. The prescaler restarts on every
    // entry into the marquee or the alarm so that the first window and the
    // first blink phase each get a full step.
    always_comb begin
        state_nxt = state;
        presc_nxt = tick ? '0 : presc + PW'(1);
        pos_nxt   = pos;
        blink_nxt = blink;

        case (state)
            S_TIME: begin
                if (bus.alarm_req) begin
                    state_nxt = S_ALARM;
                    presc_nxt = '0;
                    blink_nxt = 1'b0;
                end else if (bus.mode_btn) begin
                    state_nxt = S_DATE;
                    presc_nxt = '0;
                    pos_nxt   = 3'd0;
                end
            end
            S_DATE: begin
                if (bus.alarm_req) begin
                    state_nxt = S_ALARM;
                    presc_nxt = '0;
                    blink_nxt = 1'b0;
                end else if (tick) begin
                    if (pos == POS_LAST) begin
                        state_nxt = S_TIME;
                    end else begin
                        pos_nxt = pos + 3'd1;
                    end
                end
            end
            S_ALARM: begin
                if (!bus.alarm_req) begin
                    state_nxt = S_TIME;
                end else if (tick) begin
                    blink_nxt = ~blink;
                end
            end
            default: begin
                state_nxt = S_TIME;
            end
        endcase
    end

    // The output mux works from the current registered state. Its result is
    // registered, so the display trails the state by one cycle.
    always_comb begin
        disp_nxt = bus.time_digits;
        src_nxt  = state;
        case (state)
            S_DATE:  disp_nxt = window;
            S_ALARM: disp_nxt = blink ? BLANK : bus.alarm_digits;
            default: disp_nxt = bus.time_digits;
        endcase
    end

    assign bus.disp_code = disp_q;
    assign bus.src       = src_q;
    assign bus.step      = tick;

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scheduler
// Description : Self-checking bench for display_scheduler with TICK_DIV=4.
//               It runs directed scenarios and then random traffic. Every
//               cycle is compared against an elapsed-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scheduler;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    display_scheduler_if bus();

    display_scheduler #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model. mode is 0 time, 1 date, 2 alarm.
    // cnt is the number of cycles since the last prescaler restart.
    int          m_mode;
    int          m_cnt;
    logic [15:0] e_disp;
    logic [1:0]  e_src;

    task automatic check(input string tag, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] date_char(input int i);
        logic [39:0] d;
        d = bus.date_digits;
        return d[39 - 4*i -: 4];
    endfunction

    function automatic logic [15:0] model_view();
        int w;
        if (m_mode == 1) begin
            w = m_cnt / TD;
            return {date_char(w), date_char(w+1), date_char(w+2), date_char(w+3)};
        end else if (m_mode == 2) begin
            return (((m_cnt / TD) % 2) == 1) ? 16'hFFFF : bus.alarm_digits;
        end
        return bus.time_digits;
    endfunction

    // Advance the model by one clock edge, using the inputs that edge sees.
    task automatic model_edge();
        bit step_now;
        if (!rst_n) begin
            e_disp = 16'hFFFF;
            e_src  = 2'd0;
            m_mode = 0;
            m_cnt  = 0;
        end else begin
            e_disp   = model_view();
            e_src    = 2'(m_mode);
            step_now = (m_cnt % TD) == TD - 1;
            case (m_mode)
                0: begin
                    if (bus.alarm_req)     begin m_mode = 2; m_cnt = 0; end
                    else if (bus.mode_btn) begin m_mode = 1; m_cnt = 0; end
                    else m_cnt++;
                end
                1: begin
                    if (bus.alarm_req) begin m_mode = 2; m_cnt = 0; end
                    else begin
                        if (step_now && (m_cnt / TD) == 6) m_mode = 0;
                        m_cnt++;
                    end
                end
                default: begin
                    if (!bus.alarm_req) m_mode = 0;
                    m_cnt++;
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("disp", 40'(bus.disp_code), 40'(e_disp));
        check("src",  40'(bus.src),       40'(e_src));
        check("step", 40'(bus.step),      40'((m_cnt % TD) == TD - 1));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_mode();
        bus.mode_btn = 1'b1;
        tick();
        bus.mode_btn = 1'b0;
    endtask

    logic [15:0] marq [7] = '{16'h2023, 16'h023A, 16'h23A0, 16'h3A05,
                              16'hA05A, 16'h05A0, 16'h5A05};

    initial begin
        int n_src1;
        int n_step;
        rst_n            = 1'b0;
        bus.time_digits  = 16'h0000;
        bus.date_digits  = 40'h2023A05A05;
        bus.alarm_digits = 16'h0730;
        bus.alarm_req    = 1'b0;
        bus.mode_btn     = 1'b0;
        m_mode = 0; m_cnt = 0;

        // Reset, then time pass-through.
        ticks(3);
        check("rst_disp", 40'(bus.disp_code), 40'h0FFFF);
        check("rst_src",  40'(bus.src), 40'd0);
        bus.time_digits = 16'h1245;
        rst_n = 1'b1;
        check("rel_blank", 40'(bus.disp_code), 40'h0FFFF);
        tick();
        check("rel_time", 40'(bus.disp_code), 40'h01245);
        bus.time_digits = 16'h1246;
        tick();
        check("time_chg", 40'(bus.disp_code), 40'h01246);
        ticks(5);

        // Full marquee, checked against the literal window table.
        n_src1 = 0;
        n_step = 0;
        pulse_mode();
        for (int i = 1; i <= 29; i++) begin
            tick();
            if (bus.src == 2'd1) n_src1++;
            if (i <= 28) check("marq_win", 40'(bus.disp_code), 40'(marq[(i-1)/TD]));
            if (i == 3) check("step_first", 40'(bus.step), 40'd1);
            if (i <= 2 && bus.step) n_step++;
        end
        check("marq_end", 40'(bus.disp_code), 40'h01246);
        check("marq_len", 40'(n_src1), 40'd28);
        check("step_early", 40'(n_step), 40'd0);
        ticks(3);

        // Alarm preempts the marquee while the window at char 3 is shown.
        pulse_mode();
        ticks(13);
        bus.alarm_req = 1'b1;
        tick();
        tick();
        check("alm_src", 40'(bus.src), 40'd2);
        check("alm_show", 40'(bus.disp_code), 40'h00730);
        ticks(4);
        check("alm_blank", 40'(bus.disp_code), 40'h0FFFF);
        ticks(4);
        check("alm_again", 40'(bus.disp_code), 40'h00730);
        bus.alarm_req = 1'b0;
        ticks(2);
        check("alm_exit", 40'(bus.disp_code), 40'h01246);
        n_src1 = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (bus.src == 2'd1) n_src1++; end
        check("no_resume", 40'(n_src1), 40'd0);

        // Simultaneous request: alarm wins, and mode pulses are ignored meanwhile.
        bus.alarm_req = 1'b1;
        n_src1 = 0;
        pulse_mode();
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) pulse_mode(); else tick();
            if (bus.src == 2'd1) n_src1++;
        end
        check("simul_src", 40'(bus.src), 40'd2);
        check("simul_no_date", 40'(n_src1), 40'd0);
        bus.alarm_req = 1'b0;
        ticks(4);

        // Reset during marquee window 4.
        pulse_mode();
        ticks(18);
        rst_n = 1'b0;
        tick();
        check("midrst_disp", 40'(bus.disp_code), 40'h0FFFF);
        check("midrst_src", 40'(bus.src), 40'd0);
        rst_n = 1'b1;
        n_src1 = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (bus.src == 2'd1) n_src1++; end
        check("midrst_nodate", 40'(n_src1), 40'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) bus.alarm_req = ~bus.alarm_req;
            bus.mode_btn = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) bus.time_digits = 16'($urandom);
            if ($urandom_range(0, 49) == 0) bus.alarm_digits = 16'($urandom);
            if ($urandom_range(0, 99) == 0) bus.date_digits = {8'($urandom), 32'($urandom)};
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
